// File: rtl/cute_lock_pkg.sv
// Shared helpers for the cute_lock family of time-varying key gates:
// index-width helper, packed slot-field extraction, default key/trap tables
// and the error-counter saturation value.
package cute_lock_pkg;

  // Widest packed key/trap table and widest single field the helpers handle.
  localparam int unsigned PACK_MAX  = 1024;
  localparam int unsigned FIELD_MAX = 64;

  // Default two-slot schedule: slot 0 key 11 / trap 20, slot 1 key 29 / trap 1.
  localparam logic [9:0] DEF_KEY_VALUES  = {5'd29, 5'd11};
  localparam logic [9:0] DEF_TRAP_STATES = {5'd1, 5'd20};
  localparam int unsigned DEF_ERR_W      = 8;

  // Index width with a floor of one bit so single-entry tables still get a port.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

  // Field idx of width w from a packed table; callers truncate to w bits.
  function automatic logic [FIELD_MAX-1:0] slot_field(input logic [PACK_MAX-1:0] pack,
                                                      input int unsigned idx,
                                                      input int unsigned w);
    return FIELD_MAX'(pack >> (idx * w));
  endfunction

  function automatic logic [FIELD_MAX-1:0] key_field(input logic [PACK_MAX-1:0] keys,
                                                     input int unsigned idx,
                                                     input int unsigned key_w);
    return slot_field(keys, idx, key_w);
  endfunction

  function automatic logic [FIELD_MAX-1:0] trap_field(input logic [PACK_MAX-1:0] traps,
                                                      input int unsigned idx,
                                                      input int unsigned state_w);
    return slot_field(traps, idx, state_w);
  endfunction

  // All-ones value of a w-bit counter (w up to FIELD_MAX).
  function automatic logic [FIELD_MAX-1:0] err_sat(input int unsigned w);
    return (FIELD_MAX'(1) << w) - FIELD_MAX'(1);
  endfunction

endpackage

// File: rtl/cute_lock_sched.sv
// Key-slot scheduler: SLOT_LEN clocks per slot, NUM_KEYS slots per period.
// Free-running after reset; shared by other locked benchmarks.
module cute_lock_sched
  import cute_lock_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 2,
  parameter int unsigned SLOT_LEN = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [idx_width(NUM_KEYS)-1:0] slot_idx
);

  localparam int unsigned IDX_W = idx_width(NUM_KEYS);
  localparam int unsigned CNT_W = idx_width(SLOT_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_KEYS - 1);

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0] slot_idx_q, slot_idx_d;

  // Count within the slot; on wrap step to the next slot, wrapping the period.
  always_comb begin
    slot_cnt_d = slot_cnt_q + 1'b1;
    slot_idx_d = slot_idx_q;
    if (slot_cnt_q == CNT_LAST) begin
      slot_cnt_d = '0;
      slot_idx_d = (slot_idx_q == IDX_LAST) ? '0 : slot_idx_q + 1'b1;
    end
  end

  // Schedule registers; reset restarts at slot 0, count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q <= '0;
      slot_idx_q <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      slot_idx_q <= slot_idx_d;
    end
  end

  assign slot_idx = slot_idx_q;

endmodule

// File: rtl/cute_lock_state_gate.sv
// Time-varying key gate used as the present-state register of a host FSM.
// nx_state is accepted only while keyinput matches the active slot's key;
// otherwise the register loads that slot's trap state and err_cnt counts up.
// Optional macro LOCK_STICKY_EN: first mismatch latches locked_out and pins
// pr_state to trap values until reset.
module cute_lock_state_gate
  import cute_lock_pkg::*;
#(
  parameter int unsigned                   STATE_W     = 5,
  parameter int unsigned                   KEY_W       = 5,
  parameter int unsigned                   NUM_KEYS    = 2,
  parameter int unsigned                   SLOT_LEN    = 2,
  parameter logic [NUM_KEYS*KEY_W-1:0]     KEY_VALUES  = DEF_KEY_VALUES,
  parameter logic [NUM_KEYS*STATE_W-1:0]   TRAP_STATES = DEF_TRAP_STATES,
  parameter logic [STATE_W-1:0]            RESET_STATE = STATE_W'(1),
  parameter int unsigned                   ERR_W       = DEF_ERR_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [KEY_W-1:0]                keyinput,
  input  logic [STATE_W-1:0]              nx_state,
  output logic [STATE_W-1:0]              pr_state,
  output logic [idx_width(NUM_KEYS)-1:0]  slot_idx,
  output logic                            key_ok,
  output logic [ERR_W-1:0]                err_cnt,
  output logic                            locked_out
);

  localparam int unsigned IDX_W = idx_width(NUM_KEYS);
  localparam int unsigned TAB_N = 2 ** IDX_W;
  localparam logic [PACK_MAX-1:0] KEY_PACK  = PACK_MAX'(KEY_VALUES);
  localparam logic [PACK_MAX-1:0] TRAP_PACK = PACK_MAX'(TRAP_STATES);
  localparam logic [ERR_W-1:0]    ERR_SAT   = ERR_W'(err_sat(ERR_W));

  // Tables are padded to a power of two so any slot_idx value indexes a
  // defined entry; padding slots mirror slot 0 and are never scheduled.
  logic [KEY_W-1:0]   key_tab  [TAB_N];
  logic [STATE_W-1:0] trap_tab [TAB_N];

  for (genvar i = 0; i < TAB_N; i++) begin : g_tab
    localparam int unsigned SRC = (i < NUM_KEYS) ? i : 0;
    assign key_tab[i]  = KEY_W'(key_field(KEY_PACK, SRC, KEY_W));
    assign trap_tab[i] = STATE_W'(trap_field(TRAP_PACK, SRC, STATE_W));
  end

  cute_lock_sched #(
    .NUM_KEYS (NUM_KEYS),
    .SLOT_LEN (SLOT_LEN)
  ) u_sched (
    .clk      (clk),
    .rst_n    (rst_n),
    .slot_idx (slot_idx)
  );

  logic [STATE_W-1:0] pr_state_q, pr_state_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [STATE_W-1:0] trap_state;

  assign key_ok     = (keyinput == key_tab[slot_idx]);
  assign trap_state = trap_tab[slot_idx];

`ifdef LOCK_STICKY_EN
  logic locked_q, locked_d;

  // Gate the next state: trap on mismatch or once locked; count mismatches.
  always_comb begin
    pr_state_d = key_ok ? nx_state : trap_state;
    err_cnt_d  = err_cnt_q;
    locked_d   = locked_q | ~key_ok;
    if (locked_q) pr_state_d = trap_state;
    if (!key_ok && (err_cnt_q != ERR_SAT)) err_cnt_d = err_cnt_q + 1'b1;
  end

  // Sticky lock register; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) locked_q <= 1'b0;
    else        locked_q <= locked_d;
  end

  assign locked_out = locked_q;
`else
  // Gate the next state: trap on mismatch; count mismatches.
  always_comb begin
    pr_state_d = key_ok ? nx_state : trap_state;
    err_cnt_d  = err_cnt_q;
    if (!key_ok && (err_cnt_q != ERR_SAT)) err_cnt_d = err_cnt_q + 1'b1;
  end

  assign locked_out = 1'b0;
`endif

  // Present-state and error-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_state_q <= RESET_STATE;
      err_cnt_q  <= '0;
    end else begin
      pr_state_q <= pr_state_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign pr_state = pr_state_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_cute_lock_state_gate.sv
// Bench for cute_lock_state_gate: a default two-slot instance and a
// three-slot, one-clock-per-slot, 8-bit-key instance, both checked against a
// slot-schedule model (slot = cycles since reset / SLOT_LEN mod NUM_KEYS).
module tb_cute_lock_state_gate;

`ifdef LOCK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] key0, nx0, pr0;
  logic       sl0, ok0, lo0;
  logic [7:0] err0;

  logic [7:0] key3;
  logic [4:0] nx3, pr3;
  logic [1:0] sl3;
  logic       ok3, lo3;
  logic [7:0] err3;

  cute_lock_state_gate dut (
    .clk(clk), .rst_n(rst_n), .keyinput(key0), .nx_state(nx0),
    .pr_state(pr0), .slot_idx(sl0), .key_ok(ok0), .err_cnt(err0), .locked_out(lo0)
  );

  cute_lock_state_gate #(
    .STATE_W     (5),
    .KEY_W       (8),
    .NUM_KEYS    (3),
    .SLOT_LEN    (1),
    .KEY_VALUES  ({8'h77, 8'h3C, 8'hA5}),
    .TRAP_STATES ({5'd7, 5'd9, 5'd3}),
    .RESET_STATE (5'd1),
    .ERR_W       (8)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .keyinput(key3), .nx_state(nx3),
    .pr_state(pr3), .slot_idx(sl3), .key_ok(ok3), .err_cnt(err3), .locked_out(lo3)
  );

  int total = 0;
  int bad   = 0;

  logic [4:0] K0 [2] = '{5'd11, 5'd29};
  logic [4:0] T0 [2] = '{5'd20, 5'd1};
  logic [7:0] K3 [3] = '{8'hA5, 8'h3C, 8'h77};
  logic [4:0] T3 [3] = '{5'd3, 5'd9, 5'd7};

  int unsigned m_n0, m_n3, m_err0, m_err3;
  logic [4:0]  m_pr0, m_pr3;
  bit          m_lk0, m_lk3;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n0 = 0; m_pr0 = 5'd1; m_err0 = 0; m_lk0 = 1'b0;
    m_n3 = 0; m_pr3 = 5'd1; m_err3 = 0; m_lk3 = 1'b0;
  endtask

  task automatic check_outputs();
    check_val("pr0",   pr0,  m_pr0);
    check_val("slot0", sl0,  (m_n0 / 2) % 2);
    check_val("err0",  err0, m_err0);
    check_val("lock0", lo0,  m_lk0);
    check_val("pr3",   pr3,  m_pr3);
    check_val("slot3", sl3,  m_n3 % 3);
    check_val("err3",  err3, m_err3);
    check_val("lock3", lo3,  m_lk3);
  endtask

  // One clock: randomize the 3-slot instance, check key_ok before the edge,
  // advance the model with pre-edge inputs, check registered outputs after.
  task automatic step();
    int unsigned s0, s3;
    bit e0, e3;
    key3 = ($urandom_range(0, 2) != 0) ? K3[m_n3 % 3] : 8'($urandom);
    nx3  = 5'($urandom);
    #1;
    s0 = (m_n0 / 2) % 2;
    s3 = m_n3 % 3;
    e0 = (key0 == K0[s0]);
    e3 = (key3 == K3[s3]);
    check_val("key_ok0", ok0, e0);
    check_val("key_ok3", ok3, e3);
    @(posedge clk);
    m_pr0 = (m_lk0 || !e0) ? T0[s0] : nx0;
    if (!e0 && m_err0 < 255) m_err0++;
    if (STICKY && !e0) m_lk0 = 1'b1;
    m_n0++;
    m_pr3 = (m_lk3 || !e3) ? T3[s3] : nx3;
    if (!e3 && m_err3 < 255) m_err3++;
    if (STICKY && !e3) m_lk3 = 1'b1;
    m_n3++;
    #1;
    check_outputs();
  endtask

  task automatic good_step();
    key0 = K0[(m_n0 / 2) % 2];
    nx0  = m_pr0 + 5'd1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    key0 = '0; nx0 = '0; key3 = '0; nx3 = '0;
    model_reset();
    #12;
    check_outputs();
    rst_n = 1'b1;

    // Correct schedule: pr_state counts 1,2,3,... with no errors.
    repeat (20) good_step();

    // Key stuck at slot-1 value: slot-0 edges trap to 20.
    repeat (8) begin
      key0 = 5'd29;
      nx0  = 5'($urandom);
      step();
    end

    // Mixed correct and random keys.
    repeat (200) begin
      key0 = ($urandom_range(0, 1) != 0) ? K0[(m_n0 / 2) % 2] : 5'($urandom);
      nx0  = 5'($urandom);
      step();
    end

    // Align to slot 1, count 0, then pulse reset between edges.
    for (int i = 0; i < 8 && (m_n0 % 4) != 2; i++) good_step();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs();
    #2;
    rst_n = 1'b1;
    repeat (12) good_step();

    // Fresh reset, then key stuck at 0 long enough to saturate err_cnt.
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs();
    #2;
    rst_n = 1'b1;
    repeat (260) begin
      key0 = 5'd0;
      nx0  = 5'($urandom);
      step();
    end
    check_val("err_sat", err0, 32'd255);

    // Correct keys again: resumes progression (or stays trapped if sticky).
    repeat (8) good_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
